// File: rtl/axis_packet_sink_if.sv
// AXI-Stream link carrying TVALID/TREADY/TDATA/TLAST between a master and a slave.
// Latency: none, wires only.
// Backpressure: tready is driven by the slave and qualifies every beat.
// Ports/modports: m drives tvalid/tdata/tlast; s drives tready and sees pkt_end.
interface axis_if #(
    parameter int DATA_WIDTH    = 32,
    parameter bit TLAST_PRESENT = 1'b1
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    // Without a TLAST wire every beat is its own packet, so receivers can
    // always delimit on pkt_end regardless of how the link is configured.
    logic                  pkt_end;
    assign pkt_end = TLAST_PRESENT ? tlast : 1'b1;

    modport m (output tvalid, output tdata, output tlast, input tready);
    modport s (input tvalid, input tdata, input pkt_end, output tready);
endinterface

// File: rtl/axis_packet_sink.sv
// Store-and-forward AXI-Stream sink exposing only complete packets on a pop port.
// Latency: beat with TLAST accepted at edge N is poppable in cycle N+1; pops are zero-bubble.
// Backpressure: tready = !full while receiving; packets too large for the buffer are dropped whole.
// Ports: ACLK/ARESETn (sync, active-low); s_axis stream in; rd_valid/rd_ready/rd_data/rd_last
//        pop port; pkt_count committed packets held; drop_count saturating drops; dropping in DROP.
module axis_packet_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axis_if.s                            s_axis,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_last,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
    output logic [15:0]                  drop_count,
    output logic                         dropping
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {RECV = 1'b0, DROP = 1'b1} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       commit_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       used;
    logic [DATA_WIDTH:0] mem [DEPTH];
    logic                full;
    logic                tready;
    logic                accept;
    logic                wr_en;
    logic                commit;
    logic                pop;
    logic                pop_last;
    logic                drop_start;

    assign used       = wr_ptr - rd_ptr;
    assign full       = (used == PW'(DEPTH));
    assign accept     = s_axis.tvalid && tready;
    assign wr_en      = (state == RECV) && accept;
    assign commit     = wr_en && s_axis.pkt_end;
    assign pop        = rd_valid && rd_ready;
    assign pop_last   = pop && rd_last;
    // A full buffer with nothing committed can only be one oversized packet;
    // waiting would deadlock, so rewind and discard the rest of it.
    assign drop_start = (state == RECV) && full && (commit_ptr == rd_ptr);

    assign s_axis.tready = tready;
    assign rd_valid      = (rd_ptr != commit_ptr);
    assign rd_data       = mem[rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
    assign rd_last       = mem[rd_ptr[AW-1:0]][DATA_WIDTH];

    // State register
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RECV:    if (drop_start) state_nxt = DROP;
            DROP:    if (accept && s_axis.pkt_end) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    // Outputs depend on registered state only; no path from tvalid to tready.
    always_comb begin
        tready   = 1'b0;
        dropping = 1'b0;
        case (state)
            RECV: tready = !full;
            DROP: begin
                tready   = 1'b1;
                dropping = 1'b1;
            end
            default: begin
                tready   = 1'b0;
                dropping = 1'b0;
            end
        endcase
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.pkt_end, s_axis.tdata};
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            // drop_start implies tready=0 in RECV, so it never coincides with a write.
            if (drop_start) begin
                wr_ptr <= commit_ptr;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (s_axis.pkt_end) begin
                    commit_ptr <= wr_ptr + PW'(1);
                end
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            case ({commit, pop_last})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_packet_sink.sv
// Directed and randomized bench for axis_packet_sink (DATA_WIDTH=32, DEPTH=16).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: senders hold tvalid until tready; pops use rd_ready.
module tb_axis_packet_sink;
    logic        clk;
    logic        aresetn;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic [4:0]  pkt_count;
    logic [15:0] drop_count;
    logic        dropping;

    int vectors     = 0;
    int miscompares = 0;

    axis_if #(.DATA_WIDTH(32), .TLAST_PRESENT(1'b1)) s_if ();

    axis_packet_sink #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .ACLK       (clk),
        .ARESETn    (aresetn),
        .s_axis     (s_if.s),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .pkt_count  (pkt_count),
        .drop_count (drop_count),
        .dropping   (dropping)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int   n;
        logic ok;
        n = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        do begin
            ok = s_if.tready;
            tick();
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_beat_timeout: data %h not accepted in %0d cycles", d, n);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic pop_beat(output logic [31:0] d, output logic l, output logic ok);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (!rd_valid && n < 200) begin
            tick();
            n++;
        end
        ok = rd_valid;
        d  = rd_data;
        l  = rd_last;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        aresetn = 1'b1;
        tick();
        vectors++;
        if ({rd_valid, pkt_count, drop_count, dropping, s_if.tready} !== {1'b0, 5'd0, 16'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_state: got vld=%b cnt=%0d drop=%0d dropping=%b trdy=%b, want 0 0 0 0 1",
                     rd_valid, pkt_count, drop_count, dropping, s_if.tready);
        end
    endtask

    task automatic test_single_packet();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_beat(exp_d[i], i == 2);
            vectors++;
            if (rd_valid !== (i == 2)) begin
                miscompares++;
                $display("FAIL single_rd_valid beat%0d: got %b want %b", i, rd_valid, (i == 2));
            end
        end
        vectors++;
        if (pkt_count !== 5'd1) begin
            miscompares++;
            $display("FAIL single_pkt_count: got %0d want 1", pkt_count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, (i == 2), exp_d[i]}) begin
                miscompares++;
                $display("FAIL single_pop%0d: got vld=%b last=%b data=%h want 1 %b %h",
                         i, rd_valid, rd_last, rd_data, (i == 2), exp_d[i]);
            end
            tick();
        end
        rd_ready = 1'b0;
        vectors++;
        if ({rd_valid, pkt_count} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL single_drained: got vld=%b cnt=%0d want 0 0", rd_valid, pkt_count);
        end
    endtask

    task automatic test_store_forward();
        logic [31:0] d;
        logic        l;
        logic        ok;
        send_beat(32'hF0, 1'b0);
        send_beat(32'hF1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL sf_partial_hidden idle%0d: got rd_valid=%b want 0", i, rd_valid);
            end
            tick();
        end
        send_beat(32'hF2, 1'b1);
        vectors++;
        if ({rd_valid, rd_data} !== {1'b1, 32'hF0}) begin
            miscompares++;
            $display("FAIL sf_commit: got vld=%b data=%h want 1 000000f0", rd_valid, rd_data);
        end
        for (int i = 0; i < 3; i++) begin
            pop_beat(d, l, ok);
            vectors++;
            if ({ok, l, d} !== {1'b1, (i == 2), 32'hF0 + 32'(i)}) begin
                miscompares++;
                $display("FAIL sf_pop%0d: got ok=%b last=%b data=%h want 1 %b %h",
                         i, ok, l, d, (i == 2), 32'hF0 + 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 4; k++) begin
                send_beat(32'hC000_0000 | 32'(p * 16 + k), k == 3);
            end
        end
        vectors++;
        if ({s_if.tready, pkt_count} !== {1'b0, 5'd4}) begin
            miscompares++;
            $display("FAIL bp_full: got trdy=%b cnt=%0d want 0 4", s_if.tready, pkt_count);
        end
        // Offer one more beat while popping a single entry.
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'hEE;
        s_if.tlast  = 1'b1;
        rd_ready    = 1'b1;
        vectors++;
        if (rd_data !== 32'hC000_0000) begin
            miscompares++;
            $display("FAIL bp_pop_head: got %h want c0000000", rd_data);
        end
        tick();
        rd_ready = 1'b0;
        vectors++;
        if (s_if.tready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_tready_after_pop: got %b want 1", s_if.tready);
        end
        tick();
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        vectors++;
        if ({s_if.tready, pkt_count} !== {1'b0, 5'd5}) begin
            miscompares++;
            $display("FAIL bp_refill: got trdy=%b cnt=%0d want 0 5", s_if.tready, pkt_count);
        end
        // Drain with rd_ready held high: one beat per cycle, no bubbles across packets.
        rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_d = (i == 16) ? 32'hEE : (32'hC000_0000 | 32'((i / 4) * 16 + (i % 4)));
            vectors++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, (i % 4 == 3) || (i == 16), exp_d}) begin
                miscompares++;
                $display("FAIL bp_drain%0d: got vld=%b last=%b data=%h want 1 %b %h",
                         i, rd_valid, rd_last, rd_data, (i % 4 == 3) || (i == 16), exp_d);
            end
            tick();
        end
        rd_ready = 1'b0;
        vectors++;
        if ({rd_valid, pkt_count} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL bp_empty: got vld=%b cnt=%0d want 0 0", rd_valid, pkt_count);
        end
    endtask

    task automatic test_overflow_drop();
        logic [31:0] d;
        logic        l;
        logic        ok;
        for (int i = 0; i < 20; i++) begin
            send_beat(32'h0D00 + 32'(i), i == 19);
            if (i == 15) begin
                vectors++;
                if ({dropping, s_if.tready} !== {1'b0, 1'b0}) begin
                    miscompares++;
                    $display("FAIL drop_full_pre: got dropping=%b trdy=%b want 0 0", dropping, s_if.tready);
                end
            end
            if (i == 16) begin
                vectors++;
                if ({dropping, drop_count} !== {1'b1, 16'd1}) begin
                    miscompares++;
                    $display("FAIL drop_enter: got dropping=%b drop_count=%0d want 1 1", dropping, drop_count);
                end
            end
        end
        vectors++;
        if ({dropping, rd_valid, pkt_count} !== {1'b0, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL drop_exit: got dropping=%b vld=%b cnt=%0d want 0 0 0", dropping, rd_valid, pkt_count);
        end
        send_beat(32'hB0, 1'b0);
        send_beat(32'hB1, 1'b1);
        vectors++;
        if ({pkt_count, drop_count} !== {5'd1, 16'd1}) begin
            miscompares++;
            $display("FAIL drop_next_pkt: got cnt=%0d drop=%0d want 1 1", pkt_count, drop_count);
        end
        for (int i = 0; i < 2; i++) begin
            pop_beat(d, l, ok);
            vectors++;
            if ({ok, l, d} !== {1'b1, (i == 1), 32'hB0 + 32'(i)}) begin
                miscompares++;
                $display("FAIL drop_pop%0d: got ok=%b last=%b data=%h want 1 %b %h",
                         i, ok, l, d, (i == 1), 32'hB0 + 32'(i));
            end
        end
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_no_leftover: got rd_valid=%b want 0", rd_valid);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp_q [$];
        logic [32:0] exp_b;
        int          pkts_sent;
        int          beats_left;
        int          model_cnt;
        int          cyc;
        logic        hold;
        logic        acc;
        logic        pp;
        logic        al;
        logic [31:0] ad;
        pkts_sent  = 0;
        beats_left = 0;
        model_cnt  = 0;
        cyc        = 0;
        hold       = 1'b0;
        while ((pkts_sent < 1000 || beats_left > 0 || exp_q.size() > 0) && cyc < 60000) begin
            if (!hold) begin
                if (beats_left == 0 && pkts_sent < 1000) begin
                    beats_left = $urandom_range(1, 16);
                    pkts_sent++;
                end
                if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
                    s_if.tvalid = 1'b1;
                    s_if.tdata  = $urandom;
                    s_if.tlast  = (beats_left == 1);
                end else begin
                    s_if.tvalid = 1'b0;
                    s_if.tlast  = 1'b0;
                end
            end
            rd_ready = 1'($urandom_range(0, 1));
            acc = s_if.tvalid && s_if.tready;
            pp  = rd_valid && rd_ready;
            ad  = rd_data;
            al  = rd_last;
            if (pp) begin
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_DEAD_BEEF;
                vectors++;
                if ({al, ad} !== exp_b) begin
                    miscompares++;
                    $display("FAIL rand_data cyc%0d: got last=%b data=%h want last=%b data=%h",
                             cyc, al, ad, exp_b[32], exp_b[31:0]);
                end
            end
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back({s_if.tlast, s_if.tdata});
                beats_left--;
                if (s_if.tlast) model_cnt++;
            end
            if (pp && al) model_cnt--;
            hold = s_if.tvalid && !acc;
            vectors++;
            if (pkt_count !== 5'(model_cnt)) begin
                miscompares++;
                $display("FAIL rand_pkt_count cyc%0d: got %0d want %0d", cyc, pkt_count, model_cnt);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        rd_ready    = 1'b0;
        vectors++;
        if (cyc >= 60000) begin
            miscompares++;
            $display("FAIL rand_timeout: got %0d cycles, %0d beats pending, want completion", cyc, exp_q.size());
        end
        vectors++;
        if ({drop_count, rd_valid, pkt_count} !== {16'd1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL rand_final: got drop=%0d vld=%b cnt=%0d want 1 0 0", drop_count, rd_valid, pkt_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        l;
        logic        ok;
        send_beat(32'hD0, 1'b0);
        send_beat(32'hD1, 1'b1);
        send_beat(32'hD2, 1'b0);
        send_beat(32'hD3, 1'b1);
        send_beat(32'hD4, 1'b0);
        send_beat(32'hD5, 1'b0);
        vectors++;
        if (pkt_count !== 5'd2) begin
            miscompares++;
            $display("FAIL rstmid_pre: got cnt=%0d want 2", pkt_count);
        end
        aresetn = 1'b0;
        tick();
        vectors++;
        if ({rd_valid, pkt_count, drop_count, dropping, s_if.tready} !== {1'b0, 5'd0, 16'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL rstmid_state: got vld=%b cnt=%0d drop=%0d dropping=%b trdy=%b want 0 0 0 0 1",
                     rd_valid, pkt_count, drop_count, dropping, s_if.tready);
        end
        aresetn = 1'b1;
        tick();
        send_beat(32'hE0, 1'b0);
        send_beat(32'hE1, 1'b1);
        vectors++;
        if (pkt_count !== 5'd1) begin
            miscompares++;
            $display("FAIL rstmid_fresh_cnt: got %0d want 1", pkt_count);
        end
        for (int i = 0; i < 2; i++) begin
            pop_beat(d, l, ok);
            vectors++;
            if ({ok, l, d} !== {1'b1, (i == 1), 32'hE0 + 32'(i)}) begin
                miscompares++;
                $display("FAIL rstmid_pop%0d: got ok=%b last=%b data=%h want 1 %b %h",
                         i, ok, l, d, (i == 1), 32'hE0 + 32'(i));
            end
        end
        vectors++;
        if ({rd_valid, pkt_count} !== {1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL rstmid_empty: got vld=%b cnt=%0d want 0 0", rd_valid, pkt_count);
        end
    endtask

    initial begin
        aresetn     = 1'b0;
        rd_ready    = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        test_reset();
        test_single_packet();
        test_store_forward();
        test_backpressure();
        test_overflow_drop();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
